// File: rtl/gp_chunk_serial_adder.sv
// Multi-cycle WIDTH-bit adder resolving CHUNK bits per cycle with in-chunk prefix carries.
// Optional macro GP_SUB_EN adds an in_sub port for A-B operation.
module gp_chunk_serial_adder #(
  parameter int WIDTH = 47,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef GP_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NCHUNK  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW      = NCHUNK * CHUNK;
  localparam int IW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LAST    = NCHUNK - 1;
  // Position of bit WIDTH-1 inside the top chunk.
  localparam int TOP_BIT = WIDTH - 1 - LAST * CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    a_reg, b_reg;
  logic [PW-1:0]    a_pad, b_pad;
  logic             cin_eff;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;

  logic [CHUNK-1:0] a_chunk, b_chunk, p, g, grp_g, grp_p, chunk_sum;
  logic [CHUNK:0]   c;
  logic             last_chunk;

  // Operand padding keeps bits >= WIDTH at p=g=0; subtraction inverts only real bits.
  always_comb begin
    a_pad   = '0;
    b_pad   = '0;
    a_pad[WIDTH-1:0] = in_a;
`ifdef GP_SUB_EN
    b_pad[WIDTH-1:0] = in_sub ? ~in_b : in_b;
    cin_eff          = in_sub ? 1'b1 : in_cin;
`else
    b_pad[WIDTH-1:0] = in_b;
    cin_eff          = in_cin;
`endif
  end

  assign a_chunk    = a_reg[int'(idx_reg)*CHUNK +: CHUNK];
  assign b_chunk    = b_reg[int'(idx_reg)*CHUNK +: CHUNK];
  assign p          = a_chunk ^ b_chunk;
  assign g          = a_chunk & b_chunk;
  assign last_chunk = (idx_reg == IW'(LAST));

  // Group generate/propagate over bits [i:0], then every carry from the chunk carry-in.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    c     = '0;
    grp_g[0] = g[0];
    grp_p[0] = p[0];
    for (int i = 1; i < CHUNK; i++) begin
      grp_g[i] = g[i] | (p[i] & grp_g[i-1]);
      grp_p[i] = p[i] & grp_p[i-1];
    end
    c[0] = carry_reg;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = grp_g[i] | (grp_p[i] & carry_reg);
    end
  end

  assign chunk_sum = p ^ c[CHUNK-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a_pad;
            b_reg     <= b_pad;
            carry_reg <= cin_eff;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < CHUNK; i++) begin
            if (int'(idx_reg)*CHUNK + i < WIDTH)
              sum_reg[int'(idx_reg)*CHUNK + i] <= chunk_sum[i];
          end
          carry_reg <= c[CHUNK];
          idx_reg   <= idx_reg + 1'b1;
          // Flags come from bit WIDTH-1, never from the padded chunk carry.
          if (last_chunk) begin
            cout_reg <= c[TOP_BIT+1];
            ovf_reg  <= c[TOP_BIT+1] ^ c[TOP_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;
  assign out_ovf  = ovf_reg;

endmodule

// File: tb/tb_gp_chunk_serial_adder.sv
// Directed self-checking bench for gp_chunk_serial_adder (WIDTH=47, CHUNK=16).
module tb_gp_chunk_serial_adder;
  localparam int W = 47;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
`ifdef GP_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gp_chunk_serial_adder #(.WIDTH(47), .CHUNK(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef GP_SUB_EN
    .in_sub(in_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    total++;
    if (out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: sum=%h cout=%b ovf=%b, want 0 0 0", out_sum, out_cout, out_ovf);
    end
    $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, out_sum);
  endtask

  task automatic test_add();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vc [5];
    logic [W-1:0] es [5];
    logic         eco [5];
    logic         eov [5];
    int lat;
    va[0] = 47'h7FFF_FFFF_FFFF; vb[0] = 47'h1; vc[0] = 0; es[0] = 47'h0;            eco[0] = 1; eov[0] = 0;
    va[1] = 47'h0000_0000_FFFF; vb[1] = 47'h1; vc[1] = 0; es[1] = 47'h0000_0001_0000; eco[1] = 0; eov[1] = 0;
    va[2] = 47'h3FFF_FFFF_FFFF; vb[2] = 47'h1; vc[2] = 0; es[2] = 47'h4000_0000_0000; eco[2] = 0; eov[2] = 1;
    va[3] = 47'h0;              vb[3] = 47'h0; vc[3] = 1; es[3] = 47'h1;            eco[3] = 0; eov[3] = 0;
    va[4] = 47'h4000_0000_0000; vb[4] = 47'h4000_0000_0000; vc[4] = 0; es[4] = 47'h0; eco[4] = 1; eov[4] = 1;
    for (int k = 0; k < 5; k++) begin
      in_a = va[k]; in_b = vb[k]; in_cin = vc[k]; in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL add%0d_ready: in_ready=%b, want 1", k, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat !== 3) begin
        bad++;
        $display("FAIL add%0d_latency: got %0d cycles, want 3", k, lat);
      end
      total++;
      if (out_sum !== es[k] || out_cout !== eco[k] || out_ovf !== eov[k]) begin
        bad++;
        $display("FAIL add%0d_result: sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 k, out_sum, out_cout, out_ovf, es[k], eco[k], eov[k]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL add%0d_release: out_valid=%b in_ready=%b, want 0 1", k, out_valid, in_ready);
      end
      $display("add%0d: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               k, va[k], vb[k], vc[k], out_sum, out_cout, out_ovf, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_a = 47'h1234; in_b = 47'h1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_a = 47'h2; in_b = 47'h3; in_cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 47'h2345 || out_cout !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d: out_valid=%b in_ready=%b sum=%h cout=%b, want 1 0 2345 0",
                 k, out_valid, in_ready, out_sum, out_cout);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_accept: in_ready=%b, want 0 after accept", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 3 || out_sum !== 47'h6 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL stall_next: lat=%0d sum=%h cout=%b ovf=%b, want 3 6 0 0", lat, out_sum, out_cout, out_ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back_to_back: held 5 cycles, next op sum=%h lat=%0d", out_sum, lat);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    in_a = 47'h1234_5678_9ABC; in_b = 47'h1111_1111_1111; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_cout !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h cout=%b, want 0 1 0 0",
               out_valid, in_ready, out_sum, out_cout);
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 3 || out_sum !== 47'h2345_6789_ABCD || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrun_after: lat=%0d sum=%h cout=%b ovf=%b, want 3 234567 89abcd 0 0",
               lat, out_sum, out_cout, out_ovf);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("reset_mid_run: recovered sum=%h lat=%0d", out_sum, lat);
  endtask

`ifdef GP_SUB_EN
  task automatic test_sub();
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic [W-1:0] es [2];
    logic         eco [2];
    int lat;
    va[0] = 47'h5; vb[0] = 47'h7; es[0] = 47'h7FFF_FFFF_FFFE; eco[0] = 0;
    va[1] = 47'h7; vb[1] = 47'h5; es[1] = 47'h2;              eco[1] = 1;
    for (int k = 0; k < 2; k++) begin
      in_a = va[k]; in_b = vb[k]; in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sub = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      total++;
      if (lat !== 3 || out_sum !== es[k] || out_cout !== eco[k] || out_ovf !== 1'b0) begin
        bad++;
        $display("FAIL sub%0d: lat=%0d sum=%h cout=%b ovf=%b, want 3 %h %b 0",
                 k, lat, out_sum, out_cout, out_ovf, es[k], eco[k]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("sub%0d: a=%h b=%h -> sum=%h cout=%b", k, va[k], vb[k], out_sum, out_cout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reset_mid_run();
`ifdef GP_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
